// File: rtl/vga_rect_cmd_engine_if.sv
// Bus bundle between the rectangle engine, the shared SRAM mailbox and the VGA pixel buffer.
interface vga_rect_cmd_engine_if #(
    parameter int unsigned SRAM_AW = 8,
    parameter int unsigned COLOR_W = 8
);
    // Shared-SRAM mailbox port
    logic [SRAM_AW-1:0] sram_address;
    logic [31:0]        sram_readdata;
    logic [31:0]        sram_writedata;
    logic               sram_write;
    // VGA pixel buffer port
    logic [31:0]        vga_sram_address;
    logic [COLOR_W-1:0] vga_sram_writedata;
    logic               vga_sram_write;
    // Status
    logic               busy;
    logic [15:0]        cmds_done;

    modport master (
        output sram_address, sram_writedata, sram_write,
        output vga_sram_address, vga_sram_writedata, vga_sram_write,
        output busy, cmds_done,
        input  sram_readdata
    );

    modport slave (
        input  sram_address, sram_writedata, sram_write,
        input  vga_sram_address, vga_sram_writedata, vga_sram_write,
        input  busy, cmds_done,
        output sram_readdata
    );
endinterface

// File: rtl/vga_rect_cmd_engine.sv
// Batch rectangle engine: polls the SRAM mailbox, fetches up to MAX_CMDS commands,
// clips and rasterises each (fill or outline) one pixel per clock, then writes the
// pixel-count status word and clears the mailbox.
module vga_rect_cmd_engine #(
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480,
    parameter int unsigned SRAM_AW  = 8,
    parameter int unsigned COLOR_W  = 8,
    parameter int unsigned MAX_CMDS = 50,
    parameter int unsigned RD_LAT   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    vga_rect_cmd_engine_if.master  bus
);
    localparam logic [15:0] SW    = 16'(SCREEN_W);
    localparam logic [15:0] SH    = 16'(SCREEN_H);
    localparam logic [15:0] SW_M1 = 16'(SCREEN_W - 1);
    localparam logic [15:0] SH_M1 = 16'(SCREEN_H - 1);
    localparam logic [7:0]  LAT   = 8'(RD_LAT);

    typedef enum logic [2:0] {StPoll, StFetch, StPrep, StDraw, StNext, StWstat, StClear} state_e;

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [2:0]           word_q, word_d;
    logic [15:0]          n_q, n_d, idx_q, idx_d;
    logic [15:0]          x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic                 mode_q, mode_d;
    // xe/ye are the unclamped far edges; xb/yb are the on-screen raster limits
    logic [15:0]          xa_q, xa_d, xb_q, xb_d, xe_q, xe_d;
    logic [15:0]          ya_q, ya_d, yb_q, yb_d, ye_q, ye_d;
    logic [15:0]          x_q, x_d, y_q, y_d;
    logic [31:0]          row_q, row_d, pix_q, pix_d;
    logic [SRAM_AW-1:0]   addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 wr_q, wr_d;
    logic [31:0]          vaddr_q, vaddr_d;
    logic [COLOR_W-1:0]   vdata_q, vdata_d;
    logic                 vwr_q, vwr_d;
    logic                 busy_q, busy_d;
    logic [15:0]          done_q, done_d;

    logic [15:0] xmin, xmax, ymin, ymax;
    logic        on_edge;

    assign bus.sram_address       = addr_q;
    assign bus.sram_writedata     = wdata_q;
    assign bus.sram_write         = wr_q;
    assign bus.vga_sram_address   = vaddr_q;
    assign bus.vga_sram_writedata = vdata_q;
    assign bus.vga_sram_write     = vwr_q;
    assign bus.busy               = busy_q;
    assign bus.cmds_done          = done_q;

    // Next-state and registered-output logic for the whole command pipeline
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        n_d     = n_q;
        idx_d   = idx_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        x2_d    = x2_q;
        y2_d    = y2_q;
        color_d = color_q;
        mode_d  = mode_q;
        xa_d    = xa_q;
        xb_d    = xb_q;
        xe_d    = xe_q;
        ya_d    = ya_q;
        yb_d    = yb_q;
        ye_d    = ye_q;
        x_d     = x_q;
        y_d     = y_q;
        row_d   = row_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
        vaddr_d = vaddr_q;
        vdata_d = vdata_q;
        vwr_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;

        xmin    = (x1_q < x2_q) ? x1_q : x2_q;
        xmax    = (x1_q < x2_q) ? x2_q : x1_q;
        ymin    = (y1_q < y2_q) ? y1_q : y2_q;
        ymax    = (y1_q < y2_q) ? y2_q : y1_q;
        on_edge = !mode_q || (x_q == xa_q) || (x_q == xe_q) || (y_q == ya_q) || (y_q == ye_q);

        unique case (state_q)
            StPoll: begin
                if (cnt_q == LAT) begin
                    cnt_d = '0;
                    if (bus.sram_readdata != 32'd0) begin
                        n_d     = (bus.sram_readdata > 32'(MAX_CMDS)) ? 16'(MAX_CMDS)
                                                                      : bus.sram_readdata[15:0];
                        busy_d  = 1'b1;
                        pix_d   = '0;
                        idx_d   = '0;
                        word_d  = '0;
                        addr_d  = SRAM_AW'(1);
                        state_d = StFetch;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StFetch: begin
                if (cnt_q == LAT) begin
                    cnt_d = '0;
                    unique case (word_q)
                        3'd0:    x1_d = bus.sram_readdata[15:0];
                        3'd1:    y1_d = bus.sram_readdata[15:0];
                        3'd2:    x2_d = bus.sram_readdata[15:0];
                        3'd3:    y2_d = bus.sram_readdata[15:0];
                        default: begin
                            color_d = bus.sram_readdata[COLOR_W-1:0];
                            mode_d  = bus.sram_readdata[31];
                        end
                    endcase
                    // Address stays on the last word so no read is in flight while drawing
                    if (word_q == 3'd4) begin
                        state_d = StPrep;
                    end else begin
                        word_d = word_q + 3'd1;
                        addr_d = addr_q + SRAM_AW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StPrep: begin
                if (xmin >= SW || ymin >= SH) begin
                    state_d = StNext;
                end else begin
                    xa_d    = xmin;
                    xe_d    = xmax;
                    xb_d    = (xmax > SW_M1) ? SW_M1 : xmax;
                    ya_d    = ymin;
                    ye_d    = ymax;
                    yb_d    = (ymax > SH_M1) ? SH_M1 : ymax;
                    x_d     = xmin;
                    y_d     = ymin;
                    row_d   = 32'(ymin) * 32'(SCREEN_W);
                    state_d = StDraw;
                end
            end
            StDraw: begin
                if (on_edge) begin
                    vwr_d   = 1'b1;
                    vaddr_d = row_q + 32'(x_q);
                    vdata_d = color_q;
                    pix_d   = pix_q + 32'd1;
                end
                if (x_q == xb_q) begin
                    if (y_q == yb_q) begin
                        state_d = StNext;
                    end else begin
                        x_d   = xa_q;
                        y_d   = y_q + 16'd1;
                        row_d = row_q + 32'(SCREEN_W);
                    end
                end else begin
                    x_d = x_q + 16'd1;
                end
            end
            StNext: begin
                done_d = done_q + 16'd1;
                idx_d  = idx_q + 16'd1;
                if ((idx_q + 16'd1) < n_q) begin
                    word_d  = '0;
                    cnt_d   = '0;
                    addr_d  = addr_q + SRAM_AW'(1);
                    state_d = StFetch;
                end else begin
                    addr_d  = '1;
                    wdata_d = pix_q;
                    wr_d    = 1'b1;
                    state_d = StWstat;
                end
            end
            StWstat: begin
                addr_d  = '0;
                wdata_d = '0;
                wr_d    = 1'b1;
                state_d = StClear;
            end
            StClear: begin
                busy_d  = 1'b0;
                cnt_d   = '0;
                addr_d  = '0;
                wdata_d = '0;
                state_d = StPoll;
            end
            default: state_d = StPoll;
        endcase
    end

    // State and output registers; reset clears everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StPoll;
            cnt_q   <= '0;
            word_q  <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            color_q <= '0;
            mode_q  <= 1'b0;
            xa_q    <= '0;
            xb_q    <= '0;
            xe_q    <= '0;
            ya_q    <= '0;
            yb_q    <= '0;
            ye_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            row_q   <= '0;
            pix_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            vaddr_q <= '0;
            vdata_q <= '0;
            vwr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            x2_q    <= x2_d;
            y2_q    <= y2_d;
            color_q <= color_d;
            mode_q  <= mode_d;
            xa_q    <= xa_d;
            xb_q    <= xb_d;
            xe_q    <= xe_d;
            ya_q    <= ya_d;
            yb_q    <= yb_d;
            ye_q    <= ye_d;
            x_q     <= x_d;
            y_q     <= y_d;
            row_q   <= row_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            vaddr_q <= vaddr_d;
            vdata_q <= vdata_d;
            vwr_q   <= vwr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_vga_rect_cmd_engine.sv
// Bench for vga_rect_cmd_engine: SRAM mailbox model, pixel monitor, table vectors,
// hand-written corner sequences and randomized batches against a rectangle model.
module tb_vga_rect_cmd_engine;
    localparam int W = 640, H = 480, AW = 8, CW = 8, MAXC = 50, LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_rect_cmd_engine_if #(.SRAM_AW(AW), .COLOR_W(CW)) bus ();

    vga_rect_cmd_engine #(
        .SCREEN_W(W), .SCREEN_H(H), .SRAM_AW(AW), .COLOR_W(CW), .MAX_CMDS(MAXC), .RD_LAT(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Shared SRAM: writes land on the edge, reads arrive LAT cycles after the address
    logic [31:0] mem  [256];
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        if (bus.sram_write) mem[bus.sram_address] <= bus.sram_writedata;
        pipe[0] <= mem[bus.sram_address];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.sram_readdata = pipe[LAT-1];

    // Pixel/strobe monitor, sampled mid-cycle
    int unsigned px_addr[$];
    int unsigned px_data[$];
    int          px_cyc[$];
    int          cyc = 0, sram_wr_cnt = 0, overlap_cnt = 0, busy_hi_cnt = 0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (bus.vga_sram_write) begin
                px_addr.push_back(bus.vga_sram_address);
                px_data.push_back(32'(bus.vga_sram_writedata));
                px_cyc.push_back(cyc);
            end
            if (bus.sram_write) sram_wr_cnt <= sram_wr_cnt + 1;
            if (bus.sram_write && bus.vga_sram_write) overlap_cnt <= overlap_cnt + 1;
            if (bus.busy) busy_hi_cnt <= busy_hi_cnt + 1;
        end
    end

    int n_assert = 0, n_fail = 0;
    task automatic check(input string name, input longint got, input longint exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Command words as the HPS would write them
    logic [31:0] cw [MAXC][5];
    int          last_base;

    // Reference: enumerate the clipped rectangle row by row, keep edges only in outline mode
    task automatic model(input int ncmd, output int unsigned ea[$], output int unsigned ed[$]);
        ea.delete();
        ed.delete();
        for (int k = 0; k < ncmd; k++) begin
            int x1 = int'(cw[k][0][15:0]), y1 = int'(cw[k][1][15:0]);
            int x2 = int'(cw[k][2][15:0]), y2 = int'(cw[k][3][15:0]);
            int xa = (x1 < x2) ? x1 : x2, xb = (x1 < x2) ? x2 : x1;
            int ya = (y1 < y2) ? y1 : y2, yb = (y1 < y2) ? y2 : y1;
            bit outl = cw[k][4][31];
            if (xa >= W || ya >= H) continue;
            for (int y = ya; y <= yb && y < H; y++)
                for (int x = xa; x <= xb && x < W; x++)
                    if (!outl || x == xa || x == xb || y == ya || y == yb) begin
                        ea.push_back(32'(y * W + x));
                        ed.push_back(32'(cw[k][4][7:0]));
                    end
        end
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        int t = 0;
        while (bus.busy !== lvl && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check({name, " busy wait"}, longint'(bus.busy === lvl), 1);
    endtask

    task automatic finish_batch(input int unsigned nval, input int base, input logic [15:0] d0,
                                input string name);
        int unsigned ea[$], ed[$];
        int nc = (nval > MAXC) ? MAXC : int'(nval);
        int got_n, bad, gi;
        model(nc, ea, ed);
        wait_busy(1'b1, name);
        wait_busy(1'b0, name);
        @(negedge clk);
        got_n = px_addr.size() - base;
        check({name, " pixel count"}, got_n, ea.size());
        bad = -1;
        for (int i = 0; i < got_n && i < ea.size(); i++)
            if (bad < 0 && (px_addr[base+i] != ea[i] || px_data[base+i] != ed[i])) bad = i;
        gi = (bad < 0) ? 0 : bad;
        if (got_n > 0 && ea.size() > 0) begin
            check({name, " pixel addr"}, px_addr[base+gi], ea[gi]);
            check({name, " pixel colour"}, px_data[base+gi], ed[gi]);
        end
        check({name, " status word"}, mem[255], ea.size());
        check({name, " mailbox cleared"}, mem[0], 0);
        check({name, " cmds_done step"}, 16'(bus.cmds_done - d0), nc);
        last_base = base;
    endtask

    task automatic run_batch(input int unsigned nval, input string name);
        int nc = (nval > MAXC) ? MAXC : int'(nval);
        int base = px_addr.size();
        logic [15:0] d0 = bus.cmds_done;
        for (int k = 0; k < nc; k++)
            for (int w = 0; w < 5; w++) mem[1+5*k+w] = cw[k][w];
        mem[0] = nval;
        finish_batch(nval, base, d0, name);
    endtask

    typedef struct {
        logic [31:0] x1, y1, x2, y2, ctl;
        int          cnt, first, last, span;
        bit          interior;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int st0, seen, t, base, nb, nr, wr0, px0, bz0;
        tbl[0] = '{10, 20, 12, 21, 32'h1C, 6, 12810, 13452, 6, 0};
        tbl[1] = '{12, 21, 10, 20, 32'h1C, 6, 12810, 13452, 6, 0};
        tbl[2] = '{0, 0, 3, 3, 32'h8000_00E0, 12, 0, 1923, 16, 1};
        tbl[3] = '{630, 5, 700, 5, 32'h55, 10, 3830, 3839, 10, 0};
        tbl[4] = '{800, 5, 800, 5, 32'h66, 0, 0, 0, 0, 0};
        tbl[5] = '{32'hABCD_0005, 5, 5, 32'h0001_0005, 32'h7F00_0003, 1, 3205, 3205, 1, 0};
        tbl[6] = '{7, 1, 8, 4, 32'h8000_0042, 8, 647, 2568, 8, 0};

        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset vga_write", bus.vga_sram_write, 0);
        check("reset sram_write", bus.sram_write, 0);
        check("reset sram_address", bus.sram_address, 0);
        check("reset busy", bus.busy, 0);
        check("reset cmds_done", bus.cmds_done, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle busy", bus.busy, 0);

        // Single-command vectors
        for (int i = 0; i < 7; i++) begin
            int n;
            cw[0][0] = tbl[i].x1; cw[0][1] = tbl[i].y1; cw[0][2] = tbl[i].x2;
            cw[0][3] = tbl[i].y2; cw[0][4] = tbl[i].ctl;
            run_batch(1, $sformatf("vec%0d", i));
            n = px_addr.size() - last_base;
            check($sformatf("vec%0d table count", i), n, tbl[i].cnt);
            if (tbl[i].cnt > 0 && n > 0) begin
                check($sformatf("vec%0d first addr", i), px_addr[last_base], tbl[i].first);
                check($sformatf("vec%0d last addr", i), px_addr[last_base+n-1], tbl[i].last);
                check($sformatf("vec%0d draw span", i),
                      px_cyc[last_base+n-1] - px_cyc[last_base] + 1, tbl[i].span);
                check($sformatf("vec%0d colour", i), px_data[last_base], tbl[i].ctl[7:0]);
            end
            if (tbl[i].interior) begin
                int hits = 0;
                for (int j = last_base; j < px_addr.size(); j++)
                    if (px_addr[j] inside {641, 642, 1281, 1282}) hits++;
                check($sformatf("vec%0d interior writes", i), hits, 0);
            end
        end

        // Clipped line plus an off-screen command in one batch
        cw[0] = '{630, 5, 700, 5, 32'h21};
        cw[1] = '{800, 10, 800, 12, 32'h22};
        run_batch(2, "clip+offscreen");
        check("clip+offscreen status", mem[255], 10);

        // Idle mailbox: nothing happens
        wr0 = sram_wr_cnt; px0 = px_addr.size(); bz0 = busy_hi_cnt;
        repeat (1000) @(negedge clk);
        check("idle sram writes", sram_wr_cnt - wr0, 0);
        check("idle pixel writes", px_addr.size() - px0, 0);
        check("idle busy cycles", busy_hi_cnt - bz0, 0);

        // Oversized count is clamped
        for (int k = 0; k < MAXC; k++) cw[k] = '{k, 100, k, 100, k + 1};
        run_batch(200, "clamp N=200");

        // Randomized batches
        for (int b = 0; b < 8; b++) begin
            nb = $urandom_range(1, 6);
            for (int k = 0; k < nb; k++) begin
                int xs = $urandom_range(0, 1) ? $urandom_range(0, 30) : $urandom_range(620, 660);
                int ys = $urandom_range(0, 1) ? $urandom_range(0, 30) : $urandom_range(462, 500);
                int xo = xs + $urandom_range(0, 10), yo = ys + $urandom_range(0, 10);
                logic [31:0] r = $urandom;
                if (r[0]) begin int tmp = xs; xs = xo; xo = tmp; end
                cw[k][0] = {r[31:16], 16'(xs)};
                cw[k][1] = {r[15:0], 16'(ys)};
                cw[k][2] = {r[23:8], 16'(xo)};
                cw[k][3] = {16'h0, 16'(yo)};
                cw[k][4] = {r[1], r[30:8], 8'($urandom)};
            end
            run_batch(nb, $sformatf("rand%0d", b));
        end

        // Reset in the middle of a 100-pixel fill
        cw[0] = '{0, 10, 9, 19, 32'h33};
        for (int w = 0; w < 5; w++) mem[1+w] = cw[0][w];
        st0 = mem[255];
        mem[0] = 1;
        seen = 0; t = 0;
        while (seen < 3 && t < 5000) begin
            @(posedge clk);
            #1;
            if (bus.vga_sram_write) seen++;
            t++;
        end
        check("pixels before reset", seen, 3);
        rst = 1'b1;
        #1;
        check("midreset vga_write", bus.vga_sram_write, 0);
        check("midreset vga_address", bus.vga_sram_address, 0);
        check("midreset vga_data", bus.vga_sram_writedata, 0);
        check("midreset sram_write", bus.sram_write, 0);
        check("midreset sram_address", bus.sram_address, 0);
        check("midreset sram_writedata", bus.sram_writedata, 0);
        check("midreset busy", bus.busy, 0);
        check("midreset cmds_done", bus.cmds_done, 0);
        repeat (3) @(negedge clk);
        check("mailbox kept word0", mem[0], 1);
        check("mailbox kept status", mem[255], st0);
        base = px_addr.size();
        rst = 1'b0;
        finish_batch(1, base, 16'd0, "rerun");
        nr = px_addr.size() - base;
        check("rerun pixel total", nr, 100);

        check("sram/vga write overlap", overlap_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_rect_cmd_engine.md
# vga_rect_cmd_engine

Multi-command rectangle drawing engine between the HPS-shared on-chip SRAM mailbox and the on-chip VGA pixel buffer. The HPS writes a batch of up to MAX_CMDS rectangle commands plus a command count. The engine fetches each command, normalises it and clips it to the screen. It then rasterises it as either a filled or an outlined rectangle into the VGA buffer, one pixel per clock. When the batch is done it writes a pixel-count status word and clears the mailbox to hand control back to the HPS.

## Interface
- SCREEN_W, 640: visible width in pixels
- SCREEN_H, 480: visible height in pixels
- SRAM_AW, 8: shared-SRAM word address width
- COLOR_W, 8: pixel width written to the VGA buffer
- MAX_CMDS, 50: commands per batch; must satisfy 1+5*MAX_CMDS ≤ 2^SRAM_AW − 1
- RD_LAT, 2: cycles from sram_address change to valid sram_readdata
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous, active-high; all state and outputs clear immediately
- sram_address  out  SRAM_AW  shared-SRAM word address
- sram_readdata  in  32  shared-SRAM read data
- sram_writedata  out  32  shared-SRAM write data
- sram_write  out  1  shared-SRAM write strobe, one cycle per word
- vga_sram_address  out  32  pixel address, y*SCREEN_W + x
- vga_sram_writedata  out  COLOR_W  pixel colour
- vga_sram_write  out  1  pixel write strobe
- busy  out  1  high from batch accept to mailbox clear
- cmds_done  out  16  running count of completed commands; wraps mod 2^16; feeds the HEX display

## Operation
- Mailbox layout:
  - Word 0 = N, the command count; 0 means idle.
  - Command k (0-based) occupies words 1+5k … 5+5k, in order x1, y1, x2, y2, ctl.
  - Coordinates use bits [15:0] as unsigned values; upper bits are ignored.
  - ctl[COLOR_W-1:0] = colour; ctl[31] = mode (0 fill, 1 outline).
  - Word 2^SRAM_AW−1 = status (pixels written in the batch).
- N > MAX_CMDS is clamped to MAX_CMDS.
- State machine:
  - POLL: drive address 0 and wait RD_LAT cycles. If readdata = 0, repeat POLL. Otherwise latch N, set busy, and go to FETCH.
  - FETCH: read the 5 words of the current command sequentially, each waiting RD_LAT.
  - PREP: build xa=min(x1,x2), xb=max, ya=min(y1,y2), yb=max.
    - If xa ≥ SCREEN_W or ya ≥ SCREEN_H, the command draws nothing: go to NEXT.
    - Otherwise clamp xb to SCREEN_W−1 and yb to SCREEN_H−1.
  - DRAW: raster from (xa,ya), x fastest. Row base advances by +SCREEN_W per row; no multiplier in the loop.
    - Fill: write every pixel.
    - Outline: write only when x∈{xa,xb} or y∈{ya,yb}. Interior positions consume a cycle with no strobe.
  - NEXT: increment cmds_done and the command index. Go to FETCH if commands remain, else WSTAT.
  - WSTAT: write the pixel count to the status word.
  - CLEAR: write 0 to word 0 and drop busy. Return to POLL.
- Clipping uses the pre-clamp edge values, so a clipped outline has no edge on the screen border.
- The pixel counter is 32-bit and resets at the start of each batch.

## Timing
- Reset values: all strobes 0, all addresses and data 0, busy 0, cmds_done 0; state POLL.
- vga_sram_write is high exactly one cycle per pixel. Address and data are valid in that same cycle.
- Draw cost: (xb−xa+1)*(yb−ya+1) cycles per command, in both modes.
- Fetch cost: 5*(RD_LAT+1) cycles per command.
- sram_write and vga_sram_write are never asserted together with a new SRAM read in flight.
- Word 0 is read only in POLL. HPS writes to word 0 while busy are forbidden; the engine's CLEAR overwrites them.
- Reset mid-batch: drawing stops at once and the mailbox is left unchanged. After reset, a nonzero word 0 restarts the whole batch from command 0.
- Degenerate cases:
  - xa = xb or ya = yb gives a line.
  - x1 = x2 and y1 = y2 gives a single pixel.
  - Outline and fill are identical for rectangles 2 or fewer pixels wide or tall.

## Test plan
- N=1, fill (10,20)-(12,21), colour 0x1C → exactly 6 writes at addresses 12810, 12811, 12812, 13450, 13451, 13452, all 0x1C; status=6; word 0 cleared; cmds_done=1.
- Same command with corners given as (12,21)-(10,20) → identical write sequence, same addresses, same order.
- Outline (0,0)-(3,3), ctl=0x8000_00E0 → 12 writes, none at 641, 642, 1281 or 1282; 16 draw cycles; status=12.
- Clip: x1=630, x2=700, y1=y2=5 → 10 writes, addresses 3830 … 3839. Off-screen x1=x2=800 → 0 writes. A batch of both gives status=10, cmds_done +2.
- N=0 held → no sram_write and no vga_sram_write for 1000 cycles; busy stays 0. N=200 → exactly 50 commands executed.
- Assert reset after the 3rd pixel of a 100-pixel fill → all outputs 0 in the same cycle. After release, the batch reruns and 100 writes follow; status=100.
